// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding for the UART transmit arbiter
package uart_pkg;

   localparam int ST_W = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_LOAD      = 3'd1;
   localparam state_t ST_ISSUE     = 3'd2;
   localparam state_t ST_WAIT_BUSY = 3'd3;
   localparam state_t ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and drive handshake bundle of the transmit arbiter
interface uart_tx_arbiter_if #(
   parameter int P_REQ_NUM    = 4,
   parameter int P_DATA_WIDTH = 8
);

   logic [P_REQ_NUM-1:0]              i_req_valid;
   logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data;
   logic [P_REQ_NUM-1:0]              i_req_last;
   logic [P_REQ_NUM-1:0]              o_req_ready;
   logic [P_DATA_WIDTH-1:0]           o_user_tx_data;
   logic                              o_user_tx_valid;
   logic                              i_user_tx_ready;
   logic [P_REQ_NUM-1:0]              o_grant;
   logic                              o_busy;
   logic                              o_timeout_err;

   // Requesters plus the UART drive: they source bytes and the drive-idle flag.
   modport master (
      output i_req_valid, i_req_data, i_req_last, i_user_tx_ready,
      input  o_req_ready, o_user_tx_data, o_user_tx_valid, o_grant, o_busy, o_timeout_err
   );

   // The arbiter itself.
   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_user_tx_ready,
      output o_req_ready, o_user_tx_data, o_user_tx_valid, o_grant, o_busy, o_timeout_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick #(
   parameter int P_REQ_NUM = 4,
   parameter int PTR_W     = 2
) (
   input  logic [P_REQ_NUM-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [P_REQ_NUM-1:0] grant
);

   logic [PTR_W:0] idx_w;
   logic           found;

   // Scan from ptr upward with wrap; the first requesting index wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx_w = '0;
      for (int i = 0; i < P_REQ_NUM; i++) begin
         idx_w = {1'b0, ptr} + (PTR_W+1)'(i);
         if (idx_w >= (PTR_W+1)'(P_REQ_NUM)) begin
            idx_w = idx_w - (PTR_W+1)'(P_REQ_NUM);
         end
         if (!found && req[idx_w[PTR_W-1:0]]) begin
            grant[idx_w[PTR_W-1:0]] = 1'b1;
            found                   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART transmit drive
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int P_REQ_NUM      = 4,
   parameter int P_DATA_WIDTH   = 8,
   parameter int P_BUSY_TIMEOUT = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   uart_tx_arbiter_if.slave   bus
);

   localparam int PTR_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
   localparam int CNT_W = $clog2(P_BUSY_TIMEOUT + 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [P_REQ_NUM-1:0]    grant_q;
   logic [P_REQ_NUM-1:0]    pick;
   logic [PTR_W-1:0]        rr_ptr_q;
   logic [PTR_W-1:0]        grant_idx;
   logic [PTR_W-1:0]        next_ptr;
   logic [P_DATA_WIDTH-1:0] data_q;
   logic [P_DATA_WIDTH-1:0] sel_data;
   logic                    last_q;
   logic                    sel_last;
   logic [CNT_W-1:0]        cnt_q;
   logic                    any_req;
   logic                    xfer;
   logic                    drive_ready;
   logic                    busy_timeout;

   assign any_req     = |bus.i_req_valid;
   assign drive_ready = bus.i_user_tx_ready;
   assign xfer        = (state_q == ST_LOAD) && (|(grant_q & bus.i_req_valid));
   // The drive never dropped ready during the whole busy window.
   assign busy_timeout = (state_q == ST_WAIT_BUSY) && drive_ready &&
                         (cnt_q == CNT_W'(P_BUSY_TIMEOUT - 1));

   rr_pick #(
      .P_REQ_NUM (P_REQ_NUM),
      .PTR_W     (PTR_W)
   ) u_rr_pick (
      .req   (bus.i_req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick)
   );

   // Owner index plus its byte/last lanes, selected by the registered grant.
   always_comb begin
      grant_idx = '0;
      sel_data  = '0;
      sel_last  = 1'b0;
      for (int k = 0; k < P_REQ_NUM; k++) begin
         if (grant_q[k]) begin
            grant_idx = PTR_W'(k);
            sel_data  = bus.i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
            sel_last  = bus.i_req_last[k];
         end
      end
   end

   assign next_ptr = (grant_idx == PTR_W'(P_REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;

   // State register; reset abandons any byte in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitrate, fetch a byte, issue it, then follow the drive's ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (any_req) state_d = ST_LOAD;
         ST_LOAD:      if (xfer) state_d = ST_ISSUE;
         ST_ISSUE:     if (drive_ready) state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (!drive_ready || busy_timeout) state_d = ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (drive_ready) state_d = last_q ? ST_IDLE : ST_LOAD;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Grant, pointer, captured byte and busy-wait counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         grant_q  <= '0;
         rr_ptr_q <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) grant_q <= pick;
            end
            ST_LOAD: begin
               if (xfer) begin
                  data_q <= sel_data;
                  last_q <= sel_last;
               end
            end
            ST_ISSUE: begin
               if (drive_ready) cnt_q <= '0;
            end
            ST_WAIT_BUSY: begin
               if (drive_ready && (cnt_q != CNT_W'(P_BUSY_TIMEOUT))) cnt_q <= cnt_q + 1'b1;
            end
            ST_WAIT_IDLE: begin
               if (drive_ready && last_q) begin
                  rr_ptr_q <= next_ptr;
                  grant_q  <= '0;
               end
            end
            default: begin
               grant_q <= '0;
            end
         endcase
      end
   end

   // Handshake outputs derived from the current state.
   always_comb begin
      bus.o_req_ready     = '0;
      bus.o_user_tx_valid = 1'b0;
      bus.o_busy          = (state_q != ST_IDLE);
      bus.o_timeout_err   = busy_timeout;
      if (state_q == ST_LOAD) bus.o_req_ready = grant_q & bus.i_req_valid;
      if (state_q == ST_ISSUE) bus.o_user_tx_valid = drive_ready;
   end

   assign bus.o_grant        = grant_q;
   assign bus.o_user_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for the UART transmit arbiter
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;

   typedef struct {
      int         k;
      logic [7:0] d;
   } exp_t;

   typedef struct {
      logic [3:0]  mask;
      int          len;
      int          n;
      logic [31:0] ord;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_DATA_WIDTH(W)) bus ();

   uart_tx_arbiter #(
      .P_REQ_NUM      (N),
      .P_DATA_WIDTH   (W),
      .P_BUSY_TIMEOUT (TO)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   exp_t       sb [$];
   logic [8:0] rq [N][$];
   logic [N-1:0] hold;
   vec_t       tbl [8];
   int         n_vec, n_fail, cyc, n_fire, n_to, last_fire_cyc, drive_busy, pending;
   bit         stuck, last_fired, acc_last, rst_last;
   logic [7:0] prev_data;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic proto_fail(string name, logic [31:0] act);
      n_fail++;
      $display("FAIL %s: got %0h (cycle %0d)", name, act, cyc);
   endtask

   task automatic enq(int k, logic [7:0] d, bit last, bit expect_it);
      rq[k].push_back({last, d});
      if (expect_it) sb.push_back('{k, d});
   endtask

   task automatic set_vec(int i, logic [3:0] m, int len, int n, logic [31:0] ord);
      tbl[i].mask = m;
      tbl[i].len  = len;
      tbl[i].n    = n;
      tbl[i].ord  = ord;
   endtask

   function automatic bit queues_empty();
      for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive_inputs();
      logic [8:0]     e;
      logic [N-1:0]   v;
      logic [N-1:0]   l;
      logic [N*W-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int k = 0; k < N; k++) begin
         if (rq[k].size() > 0 && !hold[k]) begin
            e           = rq[k][0];
            v[k]        = 1'b1;
            d[k*W +: W] = e[7:0];
            l[k]        = e[8];
         end
      end
      bus.i_req_valid     = v;
      bus.i_req_data      = d;
      bus.i_req_last      = l;
      bus.i_user_tx_ready = (drive_busy == 0);
   endtask

   task automatic step();
      logic [N-1:0] acc;
      bit           fired;
      exp_t         e;
      drive_inputs();
      #1;
      if ((bus.o_req_ready & ~bus.o_grant) != '0) proto_fail("ready_outside_grant", 32'(bus.o_req_ready));
      if ($countones(bus.o_req_ready) > 1) proto_fail("ready_not_onehot", 32'(bus.o_req_ready));
      if (bus.o_user_tx_data !== prev_data && !acc_last && !rst_last)
         proto_fail("tx_data_unstable", 32'(bus.o_user_tx_data));
      acc = bus.o_req_ready & bus.i_req_valid;
      if (acc != '0 && pending != 0) proto_fail("second_accept_before_issue", 32'(acc));
      fired = (bus.o_user_tx_valid === 1'b1);
      if (fired) begin
         n_fire++;
         last_fire_cyc = cyc;
         if (sb.size() == 0) begin
            proto_fail("unexpected_byte", 32'(bus.o_user_tx_data));
         end else begin
            e = sb.pop_front();
            chk("tx_data", 32'(bus.o_user_tx_data), 32'(e.d));
            chk("tx_grant", 32'(bus.o_grant), 32'(1) << e.k);
         end
      end
      if (bus.o_timeout_err === 1'b1) begin
         n_to++;
         if (stuck) chk("timeout_delay", 32'(cyc - last_fire_cyc), 32'(TO));
         else proto_fail("unexpected_timeout", 32'(1));
      end
      prev_data = bus.o_user_tx_data;
      rst_last  = rst;
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) if (acc[k]) void'(rq[k].pop_front());
      acc_last = (acc != '0);
      if (fired) pending = 0;
      if (acc != '0) pending = 1;
      if (rst_last) pending = 0;
      if (drive_busy > 0) drive_busy--;
      if (fired && !stuck) drive_busy = 3;
      last_fired = fired;
   endtask

   task automatic run_until_idle(string name, int max);
      int i;
      for (i = 0; i < max; i++) begin
         step();
         if (sb.size() == 0 && queues_empty() && bus.o_busy === 1'b0) break;
      end
      chk({"drain_", name}, 32'(i < max), 32'(1));
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_grant"},     32'(bus.o_grant), 32'(0));
      chk({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'(0));
      chk({tag, "_tx_valid"},  32'(bus.o_user_tx_valid), 32'(0));
      chk({tag, "_tx_data"},   32'(bus.o_user_tx_data), 32'(0));
      chk({tag, "_busy"},      32'(bus.o_busy), 32'(0));
      chk({tag, "_timeout"},   32'(bus.o_timeout_err), 32'(0));
   endtask

   initial begin
      int s;
      int j;
      int fires0;
      int kk;
      int bcnt [N];

      rst = 1'b1;
      hold = '0;
      stuck = 1'b0;
      drive_busy = 0;
      pending = 0;
      n_vec = 0;
      n_fail = 0;
      cyc = 0;
      n_fire = 0;
      n_to = 0;
      last_fire_cyc = 0;
      acc_last = 1'b0;
      rst_last = 1'b1;
      last_fired = 1'b0;

      // mask, bytes per packet, bytes expected, service order (hex digit i = i-th byte's owner)
      set_vec(0, 4'b1000, 1, 1, 32'h0000_0003);
      set_vec(1, 4'b1011, 1, 3, 32'h0000_0310);
      set_vec(2, 4'b1111, 1, 4, 32'h0000_3210);
      set_vec(3, 4'b0110, 2, 4, 32'h0000_2211);
      set_vec(4, 4'b0101, 1, 2, 32'h0000_0020);
      set_vec(5, 4'b1001, 3, 6, 32'h0000_0333);
      set_vec(6, 4'b1100, 1, 2, 32'h0000_0032);
      set_vec(7, 4'b0010, 1, 1, 32'h0000_0001);

      repeat (3) step();
      rst = 1'b0;
      drive_inputs();
      #1;
      check_reset_outputs("reset");

      // single byte from req0, latency and grant release
      s = cyc;
      enq(0, 8'h55, 1'b1, 1'b1);
      run_until_idle("single", 100);
      chk("single_latency", 32'(last_fire_cyc - s), 32'(2));
      chk("single_grant_released", 32'(bus.o_grant), 32'(0));

      // table of simultaneous one- and multi-byte packets
      for (int v = 0; v < 8; v++) begin
         fires0 = n_fire;
         for (int k = 0; k < N; k++) begin
            bcnt[k] = 0;
            if (tbl[v].mask[k]) begin
               for (int b = 0; b < tbl[v].len; b++)
                  rq[k].push_back({(b == tbl[v].len - 1), 8'(k*64 + v*8 + b)});
            end
         end
         for (int i = 0; i < tbl[v].n; i++) begin
            kk = int'(tbl[v].ord[4*i +: 4]);
            sb.push_back('{kk, 8'(kk*64 + v*8 + bcnt[kk])});
            bcnt[kk]++;
         end
         run_until_idle("table", 400);
         chk("table_fires", 32'(n_fire - fires0), 32'(tbl[v].n));
      end

      // drive never drops ready: each byte times out after the busy window
      stuck = 1'b1;
      n_to = 0;
      enq(0, 8'hA5, 1'b0, 1'b1);
      enq(0, 8'h5A, 1'b1, 1'b1);
      run_until_idle("timeout", 200);
      chk("timeout_count", 32'(n_to), 32'(2));
      stuck = 1'b0;

      // reset while waiting for the drive to go busy
      stuck = 1'b1;
      enq(1, 8'h11, 1'b0, 1'b1);
      enq(1, 8'h22, 1'b1, 1'b1);
      last_fired = 1'b0;
      j = 0;
      while (!last_fired && j < 20) begin
         step();
         j++;
      end
      chk("rst_reach_issue", 32'(last_fired), 32'(1));
      chk("rst_busy_before", 32'(bus.o_busy), 32'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      rq[1].delete();
      sb.delete();
      stuck = 1'b0;
      drive_busy = 0;
      drive_inputs();
      #1;
      check_reset_outputs("midrst");
      enq(1, 8'h3C, 1'b1, 1'b1);
      run_until_idle("after_reset", 100);

      // owner stalls mid-packet while others wait
      enq(1, 8'h61, 1'b0, 1'b1);
      enq(1, 8'h62, 1'b0, 1'b1);
      enq(1, 8'h63, 1'b1, 1'b1);
      last_fired = 1'b0;
      j = 0;
      while (!last_fired && j < 20) begin
         step();
         j++;
      end
      chk("stall_first_byte", 32'(last_fired), 32'(1));
      hold[1] = 1'b1;
      enq(2, 8'h20, 1'b1, 1'b1);
      enq(0, 8'h10, 1'b1, 1'b1);
      fires0 = n_fire;
      repeat (50) step();
      chk("stall_no_tx", 32'(n_fire - fires0), 32'(0));
      chk("stall_grant", 32'(bus.o_grant), 32'(4'b0010));
      chk("stall_busy", 32'(bus.o_busy), 32'(1));
      hold = '0;
      run_until_idle("stall_resume", 200);

      // packet lock: req2's three bytes precede req0
      enq(2, 8'h01, 1'b0, 1'b1);
      enq(2, 8'h02, 1'b0, 1'b1);
      enq(2, 8'h03, 1'b1, 1'b1);
      enq(0, 8'h44, 1'b1, 1'b1);
      run_until_idle("packet_lock", 200);

      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
